// File: rtl/bcd_timer_sync.sv
// Single-clock MM:SS timer: tick prescaler plus clock-enabled BCD digit chain
// with run/pause control, up/down counting, clamped preload and wrap/done strobes.
module bcd_timer_sync #(
  parameter int unsigned DIV          = 50000000,
  parameter int unsigned MIN_TENS_MAX = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        dir,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [3:0]  dig_s0,
  output logic [3:0]  dig_s1,
  output logic [3:0]  dig_m0,
  output logic [3:0]  dig_m1,
  output logic        tick,
  output logic        wrap,
  output logic        done,
  output logic        running
);

  localparam int unsigned PW         = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [3:0]  M1_MAX     = 4'(MIN_TENS_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] presc, presc_nx;
  logic [3:0]    s0_nx, s1_nx, m0_nx, m1_nx;
  logic          tick_nx, wrap_nx, done_nx;
  logic          tick_en, all_zero;

  function automatic logic [3:0] clamp4(input logic [3:0] v, input logic [3:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  assign tick_en  = (state == S_RUN) && (presc == PRESC_LAST);
  assign all_zero = ({dig_m1, dig_m0, dig_s1, dig_s0} == 16'h0000);

  // State, prescaler, digits and strobes all register together
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      presc   <= '0;
      dig_s0  <= 4'd0;
      dig_s1  <= 4'd0;
      dig_m0  <= 4'd0;
      dig_m1  <= 4'd0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
      done    <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_nx;
      presc   <= presc_nx;
      dig_s0  <= s0_nx;
      dig_s1  <= s1_nx;
      dig_m0  <= m0_nx;
      dig_m1  <= m1_nx;
      tick    <= tick_nx;
      wrap    <= wrap_nx;
      done    <= done_nx;
      running <= (state_nx == S_RUN);
    end
  end

  // Next state and datapath; priority load > stop > tick/start
  always_comb begin
    state_nx = state;
    presc_nx = presc;
    s0_nx    = dig_s0;
    s1_nx    = dig_s1;
    m0_nx    = dig_m0;
    m1_nx    = dig_m1;
    tick_nx  = 1'b0;
    wrap_nx  = 1'b0;
    done_nx  = 1'b0;

    if (load) begin
      s0_nx = clamp4(load_val[3:0],   4'd9);
      s1_nx = clamp4(load_val[7:4],   4'd5);
      m0_nx = clamp4(load_val[11:8],  4'd9);
      m1_nx = clamp4(load_val[15:12], M1_MAX);
      if (state == S_DONE) state_nx = S_IDLE;
      if (state == S_RUN)  presc_nx = '0;
    end else if (stop) begin
      if (state == S_RUN) state_nx = S_PAUSE;
    end else if (state == S_RUN) begin
      if (tick_en) begin
        presc_nx = '0;
        if (!dir) begin
          tick_nx = 1'b1;
          if (dig_s0 == 4'd9) begin
            s0_nx = 4'd0;
            if (dig_s1 == 4'd5) begin
              s1_nx = 4'd0;
              if (dig_m0 == 4'd9) begin
                m0_nx = 4'd0;
                if (dig_m1 >= M1_MAX) begin
                  m1_nx   = 4'd0;
                  wrap_nx = 1'b1;
                end else begin
                  m1_nx = dig_m1 + 4'd1;
                end
              end else begin
                m0_nx = dig_m0 + 4'd1;
              end
            end else begin
              s1_nx = dig_s1 + 4'd1;
            end
          end else begin
            s0_nx = dig_s0 + 4'd1;
          end
        end else if (!all_zero) begin
          tick_nx = 1'b1;
          if (dig_s0 == 4'd0) begin
            s0_nx = 4'd9;
            if (dig_s1 == 4'd0) begin
              s1_nx = 4'd5;
              if (dig_m0 == 4'd0) begin
                m0_nx = 4'd9;
                m1_nx = dig_m1 - 4'd1;
              end else begin
                m0_nx = dig_m0 - 4'd1;
              end
            end else begin
              s1_nx = dig_s1 - 4'd1;
            end
          end else begin
            s0_nx = dig_s0 - 4'd1;
          end
          if ({dig_m1, dig_m0, dig_s1, dig_s0} == 16'h0001) begin
            done_nx  = 1'b1;
            state_nx = S_DONE;
          end
        end else begin
          // Running down at 00:00 (loaded or dir flipped): stop without counting
          state_nx = S_DONE;
        end
      end else begin
        presc_nx = presc + PW'(1);
      end
    end else if (start && !(dir && all_zero)) begin
      state_nx = S_RUN;
      presc_nx = '0;
    end
  end

endmodule

// File: tb/tb_bcd_timer_sync.sv
// Randomized and directed bench for bcd_timer_sync: two instances (tens max 5 and 9)
// checked every cycle against a seconds-count reference model.
module tb_bcd_timer_sync;

  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        rst, start, stop, dir, load;
  logic [15:0] load_val;
  logic [3:0]  s0_a, s1_a, m0_a, m1_a, s0_b, s1_b, m0_b, m1_b;
  logic        tick_a, wrap_a, done_a, running_a;
  logic        tick_b, wrap_b, done_b, running_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: time held as total seconds, state as small int
  int secs[2];
  int st[2];      // 0 idle, 1 run, 2 pause, 3 done
  int pc[2];
  bit tk[2], wr[2], dn[2];
  int mt[2] = '{5, 9};

  always #5 clk = ~clk;

  bcd_timer_sync #(.DIV(DIV), .MIN_TENS_MAX(5)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir), .load(load),
    .load_val(load_val), .dig_s0(s0_a), .dig_s1(s1_a), .dig_m0(m0_a), .dig_m1(m1_a),
    .tick(tick_a), .wrap(wrap_a), .done(done_a), .running(running_a)
  );

  bcd_timer_sync #(.DIV(DIV), .MIN_TENS_MAX(9)) dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir), .load(load),
    .load_val(load_val), .dig_s0(s0_b), .dig_s1(s1_b), .dig_m0(m0_b), .dig_m1(m1_b),
    .tick(tick_b), .wrap(wrap_b), .done(done_b), .running(running_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int load_secs(input int i, input logic [15:0] v);
    int m1, m0, s1, s0;
    m1 = min_int(int'(v[15:12]), mt[i]);
    m0 = min_int(int'(v[11:8]), 9);
    s1 = min_int(int'(v[7:4]), 5);
    s0 = min_int(int'(v[3:0]), 9);
    return (m1 * 10 + m0) * 60 + s1 * 10 + s0;
  endfunction

  function automatic logic [15:0] to_bcd(input int t);
    int m, s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [19:0] exp_out(input int i);
    return {to_bcd(secs[i]), tk[i], wr[i], dn[i], (st[i] == 1)};
  endfunction

  task automatic model_step(input int i);
    int top;
    top = (mt[i] * 10 + 9) * 60 + 59;
    tk[i] = 1'b0; wr[i] = 1'b0; dn[i] = 1'b0;
    if (rst) begin
      secs[i] = 0; st[i] = 0; pc[i] = 0;
    end else if (load) begin
      secs[i] = load_secs(i, load_val);
      if (st[i] == 3) st[i] = 0;
      if (st[i] == 1) pc[i] = 0;
    end else if (stop) begin
      if (st[i] == 1) st[i] = 2;
    end else if (st[i] == 1) begin
      if (pc[i] == DIV - 1) begin
        pc[i] = 0;
        if (!dir) begin
          tk[i] = 1'b1;
          if (secs[i] == top) begin secs[i] = 0; wr[i] = 1'b1; end
          else secs[i]++;
        end else if (secs[i] > 0) begin
          tk[i] = 1'b1;
          secs[i]--;
          if (secs[i] == 0) begin dn[i] = 1'b1; st[i] = 3; end
        end else begin
          st[i] = 3;
        end
      end else begin
        pc[i]++;
      end
    end else if (start && !(dir && secs[i] == 0)) begin
      st[i] = 1; pc[i] = 0;
    end
  endtask

  // Advance one clock with the current inputs and compare both instances
  task automatic step();
    model_step(0);
    model_step(1);
    @(posedge clk);
    @(negedge clk);
    check("cyc_m5", {m1_a, m0_a, s1_a, s0_a, tick_a, wrap_a, done_a, running_a}, exp_out(0));
    check("cyc_m9", {m1_b, m0_b, s1_b, s0_b, tick_b, wrap_b, done_b, running_b}, exp_out(1));
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Cycles from now until tick_a, bounded
  task automatic cycles_to_tick(output int c);
    c = 0;
    do begin
      step();
      c++;
    end while (!tick_a && c < 20);
  endtask

  initial begin
    int c;
    rst = 1'b1; start = 1'b1; stop = 1'b0; dir = 1'b0; load = 1'b0; load_val = 16'h0;
    @(negedge clk);
    steps(3);
    check("rst_state_a", {m1_a, m0_a, s1_a, s0_a, tick_a, wrap_a, done_a, running_a}, 20'h0);
    check("rst_state_b", {m1_b, m0_b, s1_b, s0_b, tick_b, wrap_b, done_b, running_b}, 20'h0);
    rst = 1'b0; start = 1'b0;
    steps(20);

    // Up-count with seconds-to-minutes carry
    load = 1'b1; load_val = 16'h0058; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    cycles_to_tick(c);
    check("first_tick_lat", c, 4);
    check("cnt_0059", {m1_a, m0_a, s1_a, s0_a}, 16'h0059);
    steps(4);
    check("carry_0100", {tick_a, m1_a, m0_a, s1_a, s0_a}, {1'b1, 16'h0100});

    // Wrap at 59:59 (instance b carries into 60:00)
    load = 1'b1; load_val = 16'h5959; step(); load = 1'b0;
    steps(4);
    check("wrap_m5", {wrap_a, m1_a, m0_a, s1_a, s0_a}, {1'b1, 16'h0000});
    check("carry_6000", {wrap_b, m1_b, m0_b, s1_b, s0_b}, {1'b0, 16'h6000});
    step();
    check("wrap_one_cycle", {wrap_a, wrap_b}, 2'b00);

    // Wrap at 99:59 on the wide instance
    load = 1'b1; load_val = 16'h9959; step(); load = 1'b0;
    steps(4);
    check("wrap_m9", {wrap_b, m1_b, m0_b, s1_b, s0_b}, {1'b1, 16'h0000});

    // Pause then resume: prescaler restarts
    steps(2);
    stop = 1'b1; step(); stop = 1'b0;
    steps(10);
    start = 1'b1; step(); start = 1'b0;
    cycles_to_tick(c);
    check("resume_lat", c, 4);

    // Down-count from 01:00 to done
    stop = 1'b1; step(); stop = 1'b0;
    dir = 1'b1; load = 1'b1; load_val = 16'h0100; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    c = 0;
    do begin
      step();
      c++;
    end while (!done_a && c < 400);
    check("done_cycles", c, 240);
    check("done_tick", {tick_a, done_a, running_a, m1_a, m0_a, s1_a, s0_a}, {3'b110, 16'h0});
    steps(50);
    start = 1'b1; step(); start = 1'b0;
    check("start_ignored", {running_a, running_b}, 2'b00);

    // Clamp and priority: load beats stop beats start
    load = 1'b1; stop = 1'b1; start = 1'b1; load_val = 16'hF97F; step();
    load = 1'b0; stop = 1'b0; start = 1'b0;
    check("clamp_m5", {running_a, m1_a, m0_a, s1_a, s0_a}, {1'b0, 16'h5959});
    check("clamp_m9", {running_b, m1_b, m0_b, s1_b, s0_b}, {1'b0, 16'h9959});

    // Reset on the cycle a tick (and wrap on instance a) would occur
    dir = 1'b0; start = 1'b1; step(); start = 1'b0;
    steps(3);
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_on_tick_a", {m1_a, m0_a, s1_a, s0_a, tick_a, wrap_a, done_a, running_a}, 20'h0);
    check("rst_on_tick_b", {m1_b, m0_b, s1_b, s0_b, tick_b, wrap_b, done_b, running_b}, 20'h0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      rst      = ($urandom_range(0, 199) == 0);
      load     = ($urandom_range(0, 24) == 0);
      stop     = ($urandom_range(0, 14) == 0);
      start    = ($urandom_range(0, 3) == 0);
      load_val = 16'($urandom);
      if ($urandom_range(0, 29) == 0) dir = ~dir;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
